// File: rtl/vga_timing_rx.sv
// VGA stream receiver: recovers pixel coordinates, measures line/frame geometry and
// tracks lock against expected timing. Define VGA_RX_CHECKSUM_EN to enable o_frame_sum.
module vga_timing_rx #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic            i_clk_pixel,
    input  logic            i_rst_n,
    input  logic            i_hsync,
    input  logic            i_vsync,
    input  logic            i_blank,
    input  logic [2:0][7:0] i_data,
    output logic [2:0][7:0] o_data,
    output logic            o_active,
    output logic [9:0]      o_x_pos,
    output logic [9:0]      o_y_pos,
    output logic            o_line_start,
    output logic            o_frame_start,
    output logic [10:0]     o_h_total,
    output logic [9:0]      o_v_total,
    output logic            o_locked,
    output logic            o_err,
    output logic [15:0]     o_frame_sum
);

    localparam logic [1:0] StUnlocked = 2'd0;
    localparam logic [1:0] StCheck    = 2'd1;
    localparam logic [1:0] StLocked   = 2'd2;

    localparam logic [10:0] HTot      = 11'(H_TOTAL);
    localparam logic [10:0] HAct      = 11'(H_ACTIVE);
    localparam logic [10:0] TimeoutM1 = 11'(2 * H_TOTAL - 1);
    localparam logic [9:0]  VTot      = 10'(V_TOTAL);
    localparam logic [9:0]  VAct      = 10'(V_ACTIVE);
    localparam logic [7:0]  LockN     = 8'(LOCK_FRAMES);

    logic            hs1_q, vs1_q, bl1_q, hs2_q, vs2_q, bl2_q;
    logic [2:0][7:0] data1_q, data_q, data_d;
    logic            active_q, active_d, line_start_q, line_start_d;
    logic            frame_start_q, frame_start_d, first_line_q, first_line_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic [10:0]     h_cnt_q, h_cnt_d, h_total_q, h_total_d, h_inc;
    logic [10:0]     line_act_q, line_act_d, line_eff;
    logic [9:0]      v_cnt_q, v_cnt_d, v_total_q, v_total_d, v_eff;
    logic [9:0]      act_lines_q, act_lines_d, act_lines_eff;
    logic            frame_ok_q, frame_ok_d, frame_ok_eff, seen_v_q, seen_v_d;
    logic [1:0]      state_q, state_d;
    logic [7:0]      gcnt_q, gcnt_d;
    logic            locked_q, locked_d, err_q, err_d;
    logic            h_fall, v_fall, act1, act_rise, line_bad, frame_good, timeout;

    assign h_fall   = hs2_q & ~hs1_q;
    assign v_fall   = vs2_q & ~vs1_q;
    assign act1     = ~bl1_q;
    assign act_rise = act1 & bl2_q;

    always_comb begin
        data_d        = data1_q;
        active_d      = act1;
        line_start_d  = act_rise;
        frame_start_d = act_rise & (first_line_q | v_fall);

        x_d = x_q;
        if (act1) begin
            x_d = bl2_q ? 10'd0 : ((x_q == 10'h3FF) ? x_q : x_q + 10'd1);
        end

        first_line_d = first_line_q | v_fall;
        y_d          = y_q;
        if (act_rise) begin
            y_d          = first_line_d ? 10'd0 : ((y_q == 10'h3FF) ? y_q : y_q + 10'd1);
            first_line_d = 1'b0;
        end

        h_inc     = (h_cnt_q == 11'h7FF) ? h_cnt_q : h_cnt_q + 11'd1;
        h_cnt_d   = h_fall ? 11'd0 : h_inc;
        h_total_d = h_fall ? h_inc : h_total_q;
        timeout   = !h_fall && (h_cnt_q == TimeoutM1);

        // The clock on which hsync falls still belongs to the line that is ending.
        line_eff   = (act1 && line_act_q != 11'h7FF) ? line_act_q + 11'd1 : line_act_q;
        line_act_d = h_fall ? 11'd0 : line_eff;
        line_bad   = h_fall && ((h_inc != HTot) || (line_eff != 11'd0 && line_eff != HAct));

        v_eff     = (h_fall && v_cnt_q != 10'h3FF) ? v_cnt_q + 10'd1 : v_cnt_q;
        v_cnt_d   = v_fall ? 10'd0 : v_eff;
        v_total_d = v_fall ? v_eff : v_total_q;

        act_lines_eff = (act_rise && act_lines_q != 10'h3FF) ? act_lines_q + 10'd1 : act_lines_q;
        act_lines_d   = v_fall ? 10'd0 : act_lines_eff;

        frame_ok_eff = frame_ok_q & ~line_bad;
        frame_ok_d   = v_fall | frame_ok_eff;
        seen_v_d     = seen_v_q | v_fall;
        frame_good   = frame_ok_eff && (v_eff == VTot) && (act_lines_eff == VAct) && seen_v_q;

        state_d = state_q;
        gcnt_d  = gcnt_q;
        err_d   = 1'b0;
        if (timeout || (v_fall && !frame_good)) begin
            err_d   = (state_q == StLocked);
            state_d = StUnlocked;
            gcnt_d  = 8'd0;
        end else if (v_fall) begin
            case (state_q)
                StUnlocked, StCheck: begin
                    gcnt_d  = gcnt_q + 8'd1;
                    state_d = (gcnt_d >= LockN) ? StLocked : StCheck;
                end
                StLocked: state_d = StLocked;
                default: begin
                    state_d = StUnlocked;
                    gcnt_d  = 8'd0;
                end
            endcase
        end
        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            bl1_q         <= 1'b1;
            hs2_q         <= 1'b1;
            vs2_q         <= 1'b1;
            bl2_q         <= 1'b1;
            data1_q       <= '0;
            data_q        <= '0;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            first_line_q  <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            h_cnt_q       <= '0;
            h_total_q     <= '0;
            line_act_q    <= '0;
            v_cnt_q       <= '0;
            v_total_q     <= '0;
            act_lines_q   <= '0;
            frame_ok_q    <= 1'b0;
            seen_v_q      <= 1'b0;
            state_q       <= StUnlocked;
            gcnt_q        <= '0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            hs1_q         <= i_hsync;
            vs1_q         <= i_vsync;
            bl1_q         <= i_blank;
            hs2_q         <= hs1_q;
            vs2_q         <= vs1_q;
            bl2_q         <= bl1_q;
            data1_q       <= i_data;
            data_q        <= data_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            first_line_q  <= first_line_d;
            x_q           <= x_d;
            y_q           <= y_d;
            h_cnt_q       <= h_cnt_d;
            h_total_q     <= h_total_d;
            line_act_q    <= line_act_d;
            v_cnt_q       <= v_cnt_d;
            v_total_q     <= v_total_d;
            act_lines_q   <= act_lines_d;
            frame_ok_q    <= frame_ok_d;
            seen_v_q      <= seen_v_d;
            state_q       <= state_d;
            gcnt_q        <= gcnt_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] acc_q, acc_d, acc_eff, frame_sum_q, frame_sum_d;

    always_comb begin
        acc_eff     = acc_q;
        if (act1) begin
            acc_eff = acc_q + {8'd0, data1_q[2]} + {8'd0, data1_q[1]} + {8'd0, data1_q[0]};
        end
        acc_d       = v_fall ? 16'd0 : acc_eff;
        frame_sum_d = v_fall ? acc_eff : frame_sum_q;
    end

    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            acc_q       <= acc_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign o_frame_sum = frame_sum_q;
`else
    assign o_frame_sum = 16'd0;
`endif

    assign o_data        = data_q;
    assign o_active      = active_q;
    assign o_x_pos       = x_q;
    assign o_y_pos       = y_q;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;
    assign o_h_total     = h_total_q;
    assign o_v_total     = v_total_q;
    assign o_locked      = locked_q;
    assign o_err         = err_q;

endmodule

// File: doc/vga_timing_rx.md
Name: vga_timing_rx

Overview:
- Receive-side counterpart of the VGA timing generator. Consumes a VGA-style stream (hsync, vsync, blank, 8-bit RGB) in the pixel clock domain.
- Recovers per-pixel x/y coordinates and measures line and frame geometry.
- Runs a lock state machine against the expected 640x480@60 timing.
- Used as a loopback checker on the generator output and as a front end for capture/overlay logic.

Parameters:
H_ACTIVE, 640, expected active pixels per line
V_ACTIVE, 480, expected active lines per frame
H_TOTAL, 800, expected clocks between hsync falling edges
V_TOTAL, 525, expected hsync falling edges between vsync falling edges
LOCK_FRAMES, 2, consecutive good frames required to assert lock

Ports:
i_clk_pixel  in  1  pixel clock
i_rst_n  in  1  reset, asynchronous assert, active-low
i_hsync  in  1  horizontal sync, active-low pulse
i_vsync  in  1  vertical sync, active-low pulse
i_blank  in  1  1 = blanking, 0 = active pixel
i_data  in  8 x3  RGB pixel data, [2]=R [1]=G [0]=B
o_data  out  8 x3  i_data delayed to align with o_x_pos/o_y_pos
o_active  out  1  registered ~i_blank, aligned
o_x_pos  out  10  recovered column of the current active pixel
o_y_pos  out  10  recovered row of the current active pixel
o_line_start  out  1  1-cycle pulse on the first active pixel of each line
o_frame_start  out  1  1-cycle pulse on pixel (0,0)
o_h_total  out  11  last measured hsync period, in clocks
o_v_total  out  10  last measured vsync period, in lines
o_locked  out  1  timing matches parameters
o_err  out  1  1-cycle pulse on loss of lock
o_frame_sum  out  16  frame checksum (optional feature)

Behaviour:
- Reset (async, i_rst_n=0):
  - All registers and outputs clear to 0, except i_hsync/i_vsync/i_blank capture regs, which reset to 1 (idle).
  - FSM enters UNLOCKED.
- Stage 1: inputs registered (s1). Edges are detected by comparing s1 with the previous s1 (s2).
- Stage 2: outputs registered from s1. Input-to-output latency is exactly 2 clocks for data, active, x, y and pulses.
- x_pos:
  - On an active pixel with the previous pixel blank → 0.
  - On an active pixel with the previous pixel active → x+1, saturating at 1023.
  - Holds while blank.
- y_pos:
  - A vsync falling edge sets first_line=1.
  - On each active rising edge: if first_line, y=0 and first_line is cleared; else y=y+1, saturating at 1023.
  - Holds while blank.
- Pulses:
  - o_line_start = active rising edge.
  - o_frame_start = active rising edge with first_line set.
- h counter:
  - Increments every clock. On an hsync falling edge, the value+1 is latched to o_h_total and the counter restarts at 0.
  - Saturates at 2047.
- v counter:
  - Counts hsync falling edges. On a vsync falling edge, it is latched to o_v_total and cleared.
  - If hsync and vsync fall in the same clock, the line is counted before the latch.
- Active measurement:
  - Per-line count of active clocks.
  - Per-frame count of lines containing at least one active clock.
- Per-frame frame_ok flag:
  - Set at each vsync falling edge.
  - Cleared by any hsync period != H_TOTAL.
  - Cleared by any nonzero line active count != H_ACTIVE.
- Frame-end check (vsync falling edge) is good iff all hold:
  - frame_ok
  - v count == V_TOTAL
  - active lines == V_ACTIVE
  - at least one previous vsync edge seen since reset (the first partial frame is always bad)
- FSM states UNLOCKED, CHECK, LOCKED, with good-frame counter gcnt:
  - UNLOCKED: good frame → CHECK, gcnt=1. Bad frame → stay.
  - CHECK: good frame → gcnt+1; when gcnt reaches LOCK_FRAMES, go to LOCKED. Bad frame → UNLOCKED, gcnt=0.
  - LOCKED: bad frame → UNLOCKED, o_err pulses 1 clock.
  - Timeout: no hsync falling edge for 2*H_TOTAL clocks → UNLOCKED from any state; o_err pulses if leaving LOCKED.
  - If LOCK_FRAMES=1, UNLOCKED goes directly to LOCKED on a good frame.
- o_locked is high in LOCKED, registered one clock after the deciding vsync edge reaches stage 1.
- Reset mid-frame: all state is discarded; the following partial frame counts as bad.

Optional Feature:
- Macro VGA_RX_CHECKSUM_EN.
- Defined:
  - A 16-bit accumulator adds R+G+B (mod 2^16) on every active pixel.
  - On a vsync falling edge, the accumulator is latched to o_frame_sum and cleared.
- Undefined: no accumulator logic; o_frame_sum is tied to 0.

Test Plan:
- Nominal 800x525 stream with active 640x480, hsync falling at clock 655 of each line (counted from the first active pixel), vsync falling on line 489. Required:
  - o_h_total=800 and o_v_total=525.
  - o_locked rises at the 3rd vsync edge after reset (LOCK_FRAMES=2); o_err never pulses.
- Coordinate check:
  - Pixel (0,0) appears 2 clocks after input, with o_frame_start=1.
  - Pixel (639,479) reports x=639, y=479.
  - o_line_start pulses 480 times per frame.
- While locked, one line has H_TOTAL=801 → at the next vsync edge, o_locked falls and o_err pulses once. Two further good frames → relock.
- Hsync held high for 1600 clocks while locked → UNLOCKED, o_err=1 at timeout, o_h_total unchanged.
- Async reset asserted mid-line at x=300 → all outputs 0 immediately. After release, the first frame is not counted; lock follows after 2 more good frames.
- With VGA_RX_CHECKSUM_EN and constant RGB=(1,1,1): o_frame_sum = 921600 mod 65536 = 4096. Without the macro: o_frame_sum=0.
